// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared constants for the memory block copier.
// Holds the FSM state codes and the default port widths.
package mem_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/mem_block_copier_if.sv
// mem_block_copier_if: single-cycle data-memory port.
// master = initiator (addr/wdata/read/write out), slave = memory (rdata out).
interface mem_block_copier_if
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_read;
  logic                  mem_write;

  modport master (
    output mem_addr,
    output mem_wdata,
    output mem_read,
    output mem_write,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr,
    input  mem_wdata,
    input  mem_read,
    input  mem_write,
    output mem_rdata
  );

endinterface

// File: rtl/mem_block_copier.sv
// mem_block_copier: DMA engine copying length words src->dst, ascending,
// 2 cycles/word. Ports: clk, rst, start/abort/src_addr/dst_addr/length in;
// busy/done/words_done out; mem = memory port master.
module mem_block_copier
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [ADDR_WIDTH-1:0] length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] words_done,
  mem_block_copier_if.master    mem
);

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] src_ptr;
  logic [ADDR_WIDTH-1:0] dst_ptr;
  logic [ADDR_WIDTH-1:0] len_r;
  logic [ADDR_WIDTH-1:0] count;
  logic [ADDR_WIDTH-1:0] count_inc;
  logic [DATA_WIDTH-1:0] buf_q;
  logic                  accept;
  logic                  last;

  // abort beats start when both arrive in IDLE
  assign accept    = start && !abort;
  assign count_inc = count + ADDR_WIDTH'(1);
  assign last      = (count_inc == len_r);

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (accept)
          state_nx = (length != '0) ? ST_READ : ST_DONE;
      end
      ST_READ: begin
        state_nx = abort ? ST_IDLE : ST_WRITE;
      end
      ST_WRITE: begin
        if (abort)
          state_nx = ST_IDLE;
        else if (last)
          state_nx = ST_DONE;
        else
          state_nx = ST_READ;
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nx;
  end

  // pointers and count advance only on a committed write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr <= '0;
      dst_ptr <= '0;
      len_r   <= '0;
      count   <= '0;
      buf_q   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            src_ptr <= src_addr;
            dst_ptr <= dst_addr;
            len_r   <= length;
            count   <= '0;
          end
        end
        ST_READ: begin
          if (!abort)
            buf_q <= mem.mem_rdata;
        end
        ST_WRITE: begin
          if (!abort) begin
            src_ptr <= src_ptr + ADDR_WIDTH'(1);
            dst_ptr <= dst_ptr + ADDR_WIDTH'(1);
            count   <= count_inc;
          end
        end
        default: ;
      endcase
    end
  end

  // port decode from registered state; abort only gates mem_write
  always_comb begin
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    unique case (1'b1)
      (state == ST_READ): begin
        mem.mem_read = 1'b1;
        mem.mem_addr = src_ptr;
      end
      (state == ST_WRITE): begin
        mem.mem_write = !abort;
        mem.mem_addr  = dst_ptr;
        mem.mem_wdata = buf_q;
      end
      default: ;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);
  assign words_done = count;

endmodule

// File: tb/tb_mem_block_copier.sv
// tb_mem_block_copier: bench for mem_block_copier with a memory responder.
// Table-driven copies, scoreboard on memory writes, hand-written corners.
module tb_mem_block_copier;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] length;
  logic        busy;
  logic        done;
  logic [15:0] words_done;

  mem_block_copier_if bus ();

  mem_block_copier dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .mem        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] mem [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic        pl_we;
  logic [15:0] pl_addr;
  logic [15:0] pl_data;

  assign bus.mem_rdata = bus.mem_read ? mem[bus.mem_addr] : '0;

  always @(posedge clk) begin
    if (pl_we)
      mem[pl_addr] <= pl_data;
    else if (bus.mem_write)
      mem[bus.mem_addr] <= bus.mem_wdata;
  end

  logic [31:0] exp_q [$];
  logic [31:0] obs_q [$];
  int          done_cnt;
  int          rd_cnt;
  int          wr_cnt;

  initial begin
    done_cnt = 0;
    rd_cnt   = 0;
    wr_cnt   = 0;
  end

  always @(negedge clk) begin
    if (bus.mem_write)
      obs_q.push_back({bus.mem_addr, bus.mem_wdata});
    done_cnt = done_cnt + int'(done);
    rd_cnt   = rd_cnt + int'(bus.mem_read);
    wr_cnt   = wr_cnt + int'(bus.mem_write);
  end

  int checks;
  int errors;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    pl_addr = a;
    pl_data = d;
    pl_we   = 1'b1;
    tick();
    pl_we   = 1'b0;
    ref_mem[a] = d;
  endtask

  // ascending reference copy; overlap replication falls out naturally
  task automatic expect_copy(input logic [15:0] s, input logic [15:0] d,
                             input int n);
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] v;
    for (int i = 0; i < n; i++) begin
      a = s + 16'(i);
      b = d + 16'(i);
      v = ref_mem[a];
      ref_mem[b] = v;
      exp_q.push_back({b, v});
    end
  endtask

  task automatic drain(input string tag);
    logic [31:0] e;
    logic [31:0] o;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() > 0) ? obs_q.pop_front() : 32'hDEAD_BEEF;
      chk({tag, "_wr"}, o, e);
    end
    chk({tag, "_extra"}, 32'(obs_q.size()), 32'd0);
    obs_q.delete();
  endtask

  typedef struct {
    string        name;
    logic [15:0]  src;
    logic [15:0]  dst;
    logic [15:0]  len;
    bit           repulse;
    logic [3:0][15:0] exp;
  } vec_t;

  vec_t vec [5];

  task automatic run_vec(input vec_t v);
    int cyc;
    bit got;
    int d0;
    int r0;
    int w0;
    expect_copy(v.src, v.dst, int'(v.len));
    d0 = done_cnt;
    r0 = rd_cnt;
    w0 = wr_cnt;
    start    = 1'b1;
    src_addr = v.src;
    dst_addr = v.dst;
    length   = v.len;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc = 0;
    got = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (v.repulse && k == 2) begin
        start    = 1'b1;
        src_addr = 16'h0020;
        dst_addr = 16'h0300;
      end
      if (k == 4)
        start = 1'b0;
      if (done) begin
        got = 1'b1;
        break;
      end
      cyc++;
    end
    chk({v.name, "_done_seen"}, 32'(got), 32'd1);
    chk({v.name, "_latency"}, 32'(cyc), 32'(2 * int'(v.len)));
    chk({v.name, "_words"}, 32'(words_done), 32'(v.len));
    @(negedge clk);
    chk({v.name, "_done_1cyc"}, {30'd0, done, busy}, 32'd0);
    chk({v.name, "_done_cnt"}, 32'(done_cnt - d0), 32'd1);
    chk({v.name, "_rd_cnt"}, 32'(rd_cnt - r0), 32'(v.len));
    chk({v.name, "_wr_cnt"}, 32'(wr_cnt - w0), 32'(v.len));
    drain(v.name);
    for (int i = 0; i < int'(v.len) && i < 4; i++)
      chk({v.name, "_mem"}, {16'd0, mem[v.dst + 16'(i)]}, {16'd0, v.exp[i]});
    tick();
  endtask

  initial begin
    int d0;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    length   = '0;
    pl_we    = 1'b0;
    pl_addr  = '0;
    pl_data  = '0;

    vec[0] = '{"basic", 16'h0010, 16'h0100, 16'd4, 1'b0,
               {16'h00D4, 16'h00C3, 16'h00B2, 16'h00A1}};
    vec[1] = '{"len0", 16'h0020, 16'h0180, 16'd0, 1'b0,
               {16'h0, 16'h0, 16'h0, 16'h0}};
    vec[2] = '{"wrap", 16'hFFFE, 16'h0200, 16'd4, 1'b0,
               {16'h0004, 16'h0003, 16'h0002, 16'h0001}};
    vec[3] = '{"repulse", 16'h0010, 16'h0140, 16'd4, 1'b1,
               {16'h00D4, 16'h00C3, 16'h00B2, 16'h00A1}};
    vec[4] = '{"overlap", 16'h0030, 16'h0031, 16'd3, 1'b0,
               {16'h0000, 16'h0007, 16'h0007, 16'h0007}};

    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_words", 32'(words_done), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_rdwr", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    chk("rst_idle", {16'd0, words_done} | {29'd0, busy, done, bus.mem_write},
        32'd0);
    tick();
    rst = 1'b0;

    poke(16'h0010, 16'h00A1);
    poke(16'h0011, 16'h00B2);
    poke(16'h0012, 16'h00C3);
    poke(16'h0013, 16'h00D4);
    poke(16'hFFFE, 16'h0001);
    poke(16'hFFFF, 16'h0002);
    poke(16'h0000, 16'h0003);
    poke(16'h0001, 16'h0004);
    poke(16'h0030, 16'h0007);
    poke(16'h0031, 16'h5555);
    poke(16'h0032, 16'h5555);
    poke(16'h0033, 16'h5555);
    poke(16'h0070, 16'h1111);
    poke(16'h0071, 16'h2222);
    poke(16'h0092, 16'hEEEE);
    poke(16'h01C0, 16'h1234);
    tick();

    for (int i = 0; i < 5; i++)
      run_vec(vec[i]);

    // abort during the third WRITE of an 8-word copy
    expect_copy(16'h0070, 16'h0090, 2);
    d0 = done_cnt;
    start    = 1'b1;
    src_addr = 16'h0070;
    dst_addr = 16'h0090;
    length   = 16'd8;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("ab_wr_pre", 32'(bus.mem_write), 32'd1);
    abort = 1'b1;
    #1;
    chk("ab_wr_gated", 32'(bus.mem_write), 32'd0);
    chk("ab_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1 abort = 1'b0;
    chk("ab_idle", 32'(busy), 32'd0);
    chk("ab_words", 32'(words_done), 32'd2);
    @(negedge clk);
    chk("ab_no_done", 32'(done_cnt - d0), 32'd0);
    drain("ab");
    chk("ab_third", {16'd0, mem[16'h0092]}, 32'h0000EEEE);
    chk("ab_first", {mem[16'h0090], mem[16'h0091]}, 32'h11112222);
    tick();

    // async reset while in WRITE
    start    = 1'b1;
    src_addr = 16'h0010;
    dst_addr = 16'h01C0;
    length   = 16'd2;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    chk("ar_wr_pre", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("ar_wr_drop", 32'(bus.mem_write), 32'd0);
    chk("ar_outs", {15'd0, busy, bus.mem_addr}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("ar_mem", {16'd0, mem[16'h01C0]}, 32'h00001234);
    chk("ar_no_wr", 32'(obs_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
